// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline sequencing controller for a 5-stage RV32I core. Produces the
//   per-stage register write-enables, the IF/ID and ID/EX bubble/flush
//   controls, and two saturating stall-statistics counters.
//
//   Handles, in priority order:
//     - data-memory wait states (full pipeline freeze)
//     - redirects (taken branch / jal / jalr) resolved in EX
//     - instruction-fetch wait states (bubble into ID/EX)
//     - load-use hazards (one bubble into ID/EX)
//   A redirect that lands while a fetch is still outstanding arms a
//   "stale fetch drop": the first fetch that completes afterwards belongs
//   to the wrong path and is squashed in IF/ID.
//
// Ports
//   clk, rst        core clock, synchronous active-high reset
//   id_rs1_s        rs1 index of the instruction in ID
//   id_rs2_s        rs2 index of the instruction in ID
//   id_uses_rs2     ID instruction actually reads rs2
//   ex_rd_s         rd index of the instruction in EX
//   ex_is_load      EX instruction is a load
//   ex_regf_we      EX instruction writes the register file
//   ex_redirect     EX resolved a taken control transfer this cycle
//   imem_wait       fetch outstanding, instruction not yet valid
//   dmem_req        MEM stage issues a load/store this cycle
//   dmem_resp       data memory response valid this cycle
//   pc_we           PC update enable
//   if_id_we        IF/ID write enable
//   id_ex_we        ID/EX write enable
//   ex_mem_we       EX/MEM write enable
//   mem_wb_we       MEM/WB write enable
//   if_id_flush     load NOP into IF/ID (together with if_id_we)
//   id_ex_flush     load bubble into ID/EX (together with id_ex_we)
//   load_stall_cnt  cycles lost to load-use bubbles (saturating)
//   mem_stall_cnt   cycles lost to imem/dmem waits (saturating)

module hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_s,
    input  logic [4:0]       id_rs2_s,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd_s,
    input  logic             ex_is_load,
    input  logic             ex_regf_we,
    input  logic             ex_redirect,
    input  logic             imem_wait,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] load_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt
);

    typedef enum logic {
        RUN,
        DMEM_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic               redirect_pend_q, redirect_pend_d;
    logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]   mem_cnt_q, mem_cnt_d;

    logic               load_use;
    logic               freeze;
    logic               load_inc;
    logic               mem_inc;

    // A load in EX whose destination is read by the ID instruction cannot be
    // forwarded in time; x0 is never a real dependency.
    assign load_use = ex_is_load && ex_regf_we && (ex_rd_s != 5'd0) &&
                      ((ex_rd_s == id_rs1_s) ||
                       (id_uses_rs2 && (ex_rd_s == id_rs2_s)));

    // In DMEM_WAIT the response cycle already behaves as RUN; in RUN a
    // zero-wait access (req and resp together) never freezes.
    assign freeze = (state_q == DMEM_WAIT) ? !dmem_resp
                                           : (dmem_req && !dmem_resp);

    always_comb begin
        pc_we           = 1'b0;
        if_id_we        = 1'b0;
        id_ex_we        = 1'b0;
        ex_mem_we       = 1'b0;
        mem_wb_we       = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        state_d         = state_q;
        redirect_pend_d = redirect_pend_q;
        load_inc        = 1'b0;
        mem_inc         = 1'b0;

        if (!rst) begin
            if (freeze) begin
                // Full freeze: every register holds, redirect_pend held.
                state_d = DMEM_WAIT;
                mem_inc = 1'b1;
            end else begin
                state_d = RUN;
                if (ex_redirect) begin
                    pc_we       = 1'b1;
                    if_id_we    = 1'b1;
                    id_ex_we    = 1'b1;
                    ex_mem_we   = 1'b1;
                    mem_wb_we   = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (imem_wait || load_use) begin
                    // Hold PC and IF/ID, push a bubble into ID/EX, let the
                    // older instructions drain.
                    id_ex_we    = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_we   = 1'b1;
                    mem_wb_we   = 1'b1;
                    if (imem_wait) begin
                        mem_inc = 1'b1;
                    end else begin
                        load_inc = 1'b1;
                    end
                end else begin
                    pc_we     = 1'b1;
                    if_id_we  = 1'b1;
                    id_ex_we  = 1'b1;
                    ex_mem_we = 1'b1;
                    mem_wb_we = 1'b1;
                end

                // The fetch completing now was issued before the redirect:
                // squash it. A redirect in this cycle cannot re-arm the drop
                // because no fetch is outstanding.
                if (redirect_pend_q && !imem_wait) begin
                    if_id_flush     = 1'b1;
                    redirect_pend_d = 1'b0;
                end else if (ex_redirect && imem_wait) begin
                    redirect_pend_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        load_cnt_d = load_cnt_q;
        mem_cnt_d  = mem_cnt_q;
        if (load_inc && (load_cnt_q != '1)) begin
            load_cnt_d = load_cnt_q + CNT_W'(1);
        end
        if (mem_inc && (mem_cnt_q != '1)) begin
            mem_cnt_d = mem_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            redirect_pend_q <= 1'b0;
            load_cnt_q      <= '0;
            mem_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            redirect_pend_q <= redirect_pend_d;
            load_cnt_q      <= load_cnt_d;
            mem_cnt_q       <= mem_cnt_d;
        end
    end

    assign load_stall_cnt = load_cnt_q;
    assign mem_stall_cnt  = mem_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Bench for hazard_ctrl. A behavioural model tracks "waiting on dmem",
//   "stale fetch pending" and the two counters as plain bits/integers and
//   derives the expected enables from the priority rules. One compare
//   process checks every output on every falling edge. Directed scenarios
//   add hand-computed literal expectations, followed by random traffic.
//   Counters are built 4 bits wide so saturation is reachable.

module tb_hazard_ctrl;

    localparam int CW  = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    id_rs1_s = '0, id_rs2_s = '0, ex_rd_s = '0;
    logic          id_uses_rs2 = 1'b0, ex_is_load = 1'b0, ex_regf_we = 1'b0;
    logic          ex_redirect = 1'b0, imem_wait = 1'b0;
    logic          dmem_req = 1'b0, dmem_resp = 1'b0;
    logic          pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic          if_id_flush, id_ex_flush;
    logic [CW-1:0] load_stall_cnt, mem_stall_cnt;

    int checks   = 0;
    int failures = 0;

    // model state
    bit m_dwait = 1'b0;
    bit m_pend  = 1'b0;
    int m_ld    = 0;
    int m_mem   = 0;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_s(id_rs1_s), .id_rs2_s(id_rs2_s), .id_uses_rs2(id_uses_rs2),
        .ex_rd_s(ex_rd_s), .ex_is_load(ex_is_load), .ex_regf_we(ex_regf_we),
        .ex_redirect(ex_redirect), .imem_wait(imem_wait),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .load_stall_cnt(load_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Expected outputs {pc,if_id,id_ex,ex_mem,mem_wb,if_id_fl,id_ex_fl}
    // plus next model state from the current model state and inputs.
    function automatic void model(output bit [6:0] o, output bit nd, output bit np,
                                  output bit inc_ld, output bit inc_mem);
        bit lu, frz;
        lu = ex_is_load && ex_regf_we && ex_rd_s != 0 &&
             (ex_rd_s == id_rs1_s || (id_uses_rs2 && ex_rd_s == id_rs2_s));
        o = 7'b0; nd = 1'b0; np = m_pend; inc_ld = 1'b0; inc_mem = 1'b0;
        if (rst) begin
            np = 1'b0;
            return;
        end
        frz = m_dwait ? !dmem_resp : (dmem_req && !dmem_resp);
        if (frz) begin
            nd = 1'b1; inc_mem = 1'b1;
            return;
        end
        if (ex_redirect)    o = 7'b1111111;
        else if (imem_wait) begin o = 7'b0011101; inc_mem = 1'b1; end
        else if (lu)        begin o = 7'b0011101; inc_ld  = 1'b1; end
        else                o = 7'b1111100;
        if (m_pend && !imem_wait) begin
            o[1] = 1'b1; np = 1'b0;
        end else if (ex_redirect && imem_wait) begin
            np = 1'b1;
        end
    endfunction

    always @(posedge clk) begin
        bit [6:0] o; bit nd, np, il, im;
        model(o, nd, np, il, im);
        m_dwait <= nd;
        m_pend  <= np;
        if (rst) begin
            m_ld <= 0; m_mem <= 0;
        end else begin
            if (il) m_ld  <= (m_ld  < SAT) ? m_ld  + 1 : SAT;
            if (im) m_mem <= (m_mem < SAT) ? m_mem + 1 : SAT;
        end
    end

    // single compare process
    always @(negedge clk) begin
        bit [6:0] o; bit nd, np, il, im;
        model(o, nd, np, il, im);
        check("pc_we",          int'(pc_we),          int'(o[6]));
        check("if_id_we",       int'(if_id_we),       int'(o[5]));
        check("id_ex_we",       int'(id_ex_we),       int'(o[4]));
        check("ex_mem_we",      int'(ex_mem_we),      int'(o[3]));
        check("mem_wb_we",      int'(mem_wb_we),      int'(o[2]));
        check("if_id_flush",    int'(if_id_flush),    int'(o[1]));
        check("id_ex_flush",    int'(id_ex_flush),    int'(o[0]));
        check("load_stall_cnt", int'(load_stall_cnt), m_ld);
        check("mem_stall_cnt",  int'(mem_stall_cnt),  m_mem);
    end

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1_s = 5'd0; id_rs2_s = 5'd0; id_uses_rs2 = 1'b0;
        ex_rd_s = 5'd0; ex_is_load = 1'b0; ex_regf_we = 1'b0;
        ex_redirect = 1'b0; imem_wait = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic use2);
        ex_is_load = 1'b1; ex_regf_we = 1'b1; ex_rd_s = rd;
        id_rs1_s = rs1; id_rs2_s = rs2; id_uses_rs2 = use2;
    endtask

    initial begin
        cyc();
        #2;
        check("lit_rst_pc_we", int'(pc_we), 0);
        check("lit_rst_id_ex_we", int'(id_ex_we), 0);
        do_reset();
        #2;
        check("lit_rst_ldcnt", int'(load_stall_cnt), 0);
        check("lit_rst_memcnt", int'(mem_stall_cnt), 0);

        // load-use: lw x5 in EX, add x6,x5,x1 in ID
        set_load(5'd5, 5'd5, 5'd1, 1'b1);
        #2;
        check("lit_lu_pc_we", int'(pc_we), 0);
        check("lit_lu_if_id_we", int'(if_id_we), 0);
        check("lit_lu_id_ex_flush", int'(id_ex_flush), 1);
        cyc();
        idle_inputs();
        #2;
        check("lit_lu_cnt", int'(load_stall_cnt), 1);
        check("lit_lu_after_pc_we", int'(pc_we), 1);

        // no hazard on x0, nor on an rs2 match that is not read
        set_load(5'd0, 5'd0, 5'd0, 1'b1);
        #2;
        check("lit_lu_x0", int'(pc_we), 1);
        cyc();
        set_load(5'd7, 5'd3, 5'd7, 1'b0);
        #2;
        check("lit_lu_rs2_unused", int'(if_id_we), 1);
        cyc();
        set_load(5'd7, 5'd3, 5'd7, 1'b1);
        #2;
        check("lit_lu_rs2_used", int'(if_id_we), 0);
        cyc();
        idle_inputs();

        // dmem wait of 3 cycles
        do_reset();
        dmem_req = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            #2;
            check("lit_dmem_freeze", int'(ex_mem_we), 0);
            cyc();
        end
        dmem_req = 1'b0; dmem_resp = 1'b1;
        #2;
        check("lit_dmem_resp_we", int'(mem_wb_we), 1);
        check("lit_dmem_cnt", int'(mem_stall_cnt), 3);
        cyc();
        idle_inputs();

        // redirect overriding load-use
        do_reset();
        set_load(5'd5, 5'd5, 5'd1, 1'b1);
        ex_redirect = 1'b1;
        #2;
        check("lit_redir_pc_we", int'(pc_we), 1);
        check("lit_redir_if_id_flush", int'(if_id_flush), 1);
        check("lit_redir_id_ex_flush", int'(id_ex_flush), 1);
        cyc();
        idle_inputs();
        #2;
        check("lit_redir_ldcnt", int'(load_stall_cnt), 0);

        // redirect during a fetch wait, fetch completes two cycles later
        do_reset();
        ex_redirect = 1'b1; imem_wait = 1'b1;
        cyc();
        ex_redirect = 1'b0;
        #2;
        check("lit_pend_wait1_flush", int'(if_id_flush), 0);
        cyc();
        cyc();
        imem_wait = 1'b0;
        #2;
        check("lit_pend_drop_flush", int'(if_id_flush), 1);
        check("lit_pend_drop_pc_we", int'(pc_we), 1);
        cyc();
        #2;
        check("lit_pend_cleared", int'(if_id_flush), 0);
        check("lit_pend_memcnt", int'(mem_stall_cnt), 2);

        // reset abandons DMEM_WAIT; later response is ignored
        do_reset();
        dmem_req = 1'b1;
        cyc();
        cyc();
        rst = 1'b1; dmem_req = 1'b0;
        cyc();
        rst = 1'b0; dmem_resp = 1'b1;
        #2;
        check("lit_rstmid_pc_we", int'(pc_we), 1);
        check("lit_rstmid_memcnt", int'(mem_stall_cnt), 0);
        cyc();
        idle_inputs();

        // saturation
        imem_wait = 1'b1;
        for (int unsigned i = 0; i < 20; i++) cyc();
        imem_wait = 1'b0;
        #2;
        check("lit_sat_memcnt", int'(mem_stall_cnt), SAT);
        cyc();

        // random traffic
        for (int unsigned i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(199) == 0);
            id_rs1_s    = 5'($urandom_range(3));
            id_rs2_s    = 5'($urandom_range(3));
            id_uses_rs2 = 1'($urandom_range(1));
            ex_rd_s     = 5'($urandom_range(3));
            ex_is_load  = 1'($urandom_range(1));
            ex_regf_we  = ($urandom_range(3) != 0);
            ex_redirect = ($urandom_range(7) == 0);
            imem_wait   = ($urandom_range(3) == 0);
            dmem_req    = ($urandom_range(5) == 0);
            dmem_resp   = ($urandom_range(2) == 0);
            cyc();
        end

        idle_inputs();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
